image_writer: RTL and testbench
===============================

IMAGE_WRITER -- requirements
Module: image_writer

Interface
REQ-001 Parameter NCOLS, default 80, bits per frame-buffer row (columns).
REQ-002 Parameter NROWS, default 60, rows per frame buffer.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rstn  in  1  reset, asynchronous, active-low.
REQ-005 row_data  in  NCOLS  one generation row; bit c is column c.
REQ-006 row_valid  in  1  row_data valid; held until accepted.
REQ-007 row_ready  out  1  writer can accept a row this cycle.
REQ-008 clear_req  in  1  request to zero the whole frame buffer.
REQ-009 rowW  out  7  frame-buffer write row address.
REQ-010 colW  out  7  frame-buffer write column address.
REQ-011 we  out  1  frame-buffer write enable, one bit written per cycle.
REQ-012 dataW  out  1  frame-buffer write data.
REQ-013 cur_row  out  7  row the next accepted row will be written to.
REQ-014 row_done  out  1  one-cycle pulse: row or clear sequence finished.

Function
REQ-015 States SHALL be IDLE, WRITE_ROW, CLEAR; rowW, colW, we, dataW, row_done SHALL be registered.
REQ-016 row_ready SHALL equal (state==IDLE) && !clear_req, combinationally.
REQ-017 Accept SHALL occur at an edge where row_valid && row_ready; row_data latched into an internal NCOLS-bit register at that edge.
REQ-018 At accept edge k: state->WRITE_ROW, we<=1, rowW<=cur_row, colW<=0, dataW<=row_data[0].
REQ-019 At edges k+1..k+NCOLS-1: colW increments by 1, dataW<=latched bit [colW+1], we stays 1, rowW constant.
REQ-020 At edge k+NCOLS: we<=0, state->IDLE, row_done<=1 for exactly one cycle, cur_row increments.
REQ-021 cur_row SHALL wrap NROWS-1 -> 0 (scrolling frame); no other value beyond NROWS-1 ever appears.
REQ-022 Minimum row-to-row spacing SHALL be NCOLS+1 cycles (next accept earliest at edge k+NCOLS+1).
REQ-023 clear_req sampled high in IDLE at edge j: state->CLEAR, we<=1, dataW<=0, rowW<=0, colW<=0.
REQ-024 In CLEAR: colW steps 0..NCOLS-1 per cycle, then colW<=0 and rowW+1, through rowW=NROWS-1; NROWS*NCOLS write cycles total, dataW always 0.
REQ-025 End of CLEAR (edge j+NROWS*NCOLS): we<=0, cur_row<=0, row_done pulse, state->IDLE.
REQ-026 clear_req and row_valid both high in IDLE: clear SHALL win; row not accepted (row_ready low), row_valid must stay held.
REQ-027 clear_req and row_valid SHALL be ignored outside IDLE; no queuing.
REQ-028 Changes to row_data after accept SHALL not affect written bits.
REQ-029 In IDLE, we SHALL be 0; rowW/colW/dataW hold last values and carry no meaning.

Reset
REQ-030 rstn low SHALL immediately force state=IDLE, we=0, row_done=0, dataW=0, rowW=0, colW=0, cur_row=0, latched row=0.
REQ-031 Reset mid-WRITE_ROW or mid-CLEAR SHALL abort the sequence; no further writes; partially written row is not resumed.
REQ-032 After rstn release, row_ready SHALL be 1 on the first cycle if clear_req is low.

Verification
REQ-033 Reset, row_data=80'h1 (bit0 set), row_valid=1 one accept -> 80 write cycles rowW=0, colW 0..79, dataW=1 only at colW=0, row_done one cycle after last write, cur_row=1.
REQ-034 Stream 61 rows back-to-back (row_valid held) -> accepts spaced 81 cycles, rows written to 0..59 then row 60 written to rowW=0; cur_row=1 at end.
REQ-035 clear_req=1 with row_valid=1 in IDLE -> row_ready=0, 4800 writes of dataW=0 covering every (row,col) once, row_done, cur_row=0, then row accepted to rowW=0.
REQ-036 Deassert rstn at write colW=40 of row 3 -> we=0 asynchronously, cur_row=0, no further writes, row_ready=1 after release.
REQ-037 Change row_data every cycle after accept of 80'hAAAA_AAAA_AAAA_AAAA_AAAA -> written pattern alternates 0,1 starting dataW=0 at colW=0, unaffected by input changes.
REQ-038 clear_req pulsed during WRITE_ROW -> ignored; row completes normally, no CLEAR entered.

Source files
------------

// File: rtl/image_writer_if.sv
// Row-input and frame-buffer write bundle for image_writer.
// master: row producer / fb observer; slave: the writer.
interface image_writer_if #(
  parameter int NCOLS = 80
);
  logic [NCOLS-1:0] row_data;
  logic             row_valid;
  logic             row_ready;
  logic             clear_req;
  logic [6:0]       rowW;
  logic [6:0]       colW;
  logic             we;
  logic             dataW;
  logic [6:0]       cur_row;
  logic             row_done;

  modport master (
    output row_data, row_valid, clear_req,
    input  row_ready, rowW, colW, we,
    input  dataW, cur_row, row_done
  );

  modport slave (
    input  row_data, row_valid, clear_req,
    output row_ready, rowW, colW, we,
    output dataW, cur_row, row_done
  );
endinterface

// File: rtl/image_writer.sv
// Serialises accepted rows (or a full clear) into 1-bit frame-buffer writes.
// Ports: clk, rstn (async active-low), bus (image_writer_if.slave).
module image_writer #(
  parameter int NCOLS = 80,
  parameter int NROWS = 60
) (
  input  logic           clk,
  input  logic           rstn,
  image_writer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_ROW,
    CLEAR
  } state_t;

  localparam logic [6:0] LASTC = 7'(NCOLS - 1);
  localparam logic [6:0] LASTR = 7'(NROWS - 1);

  state_t           state_q;
  logic [NCOLS-1:0] row_q;
  logic [6:0]       rowW_q;
  logic [6:0]       colW_q;
  logic             we_q;
  logic             dataW_q;
  logic [6:0]       cur_row_q;
  logic             row_done_q;
  logic [6:0]       col_d;

  always_comb begin
    col_d = colW_q + 7'd1;
  end

  assign bus.row_ready = (state_q == IDLE) &&
                         !bus.clear_req;
  assign bus.rowW      = rowW_q;
  assign bus.colW      = colW_q;
  assign bus.we        = we_q;
  assign bus.dataW     = dataW_q;
  assign bus.cur_row   = cur_row_q;
  assign bus.row_done  = row_done_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      row_q      <= '0;
      rowW_q     <= '0;
      colW_q     <= '0;
      we_q       <= 1'b0;
      dataW_q    <= 1'b0;
      cur_row_q  <= '0;
      row_done_q <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // clear has priority; row_valid stays pending
          if (bus.clear_req) begin
            state_q <= CLEAR;
            we_q    <= 1'b1;
            dataW_q <= 1'b0;
            rowW_q  <= '0;
            colW_q  <= '0;
          end else if (bus.row_valid) begin
            state_q <= WRITE_ROW;
            row_q   <= bus.row_data;
            we_q    <= 1'b1;
            rowW_q  <= cur_row_q;
            colW_q  <= '0;
            dataW_q <= bus.row_data[0];
          end
        end
        WRITE_ROW: begin
          if (colW_q == LASTC) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            row_done_q <= 1'b1;
            cur_row_q  <= (cur_row_q == LASTR) ?
                          7'd0 : cur_row_q + 7'd1;
          end else begin
            colW_q  <= col_d;
            dataW_q <= row_q[col_d];
          end
        end
        CLEAR: begin
          if (colW_q != LASTC) begin
            colW_q <= col_d;
          end else if (rowW_q != LASTR) begin
            colW_q <= '0;
            rowW_q <= rowW_q + 7'd1;
          end else begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            cur_row_q  <= '0;
            row_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_writer.sv
// Scoreboard bench for image_writer: random rows, clears, resets.
// Expected writes are queued at issue; a negedge monitor checks them.
module tb_image_writer;
  localparam int NC = 80;
  localparam int NR = 60;

  typedef struct {
    logic [6:0] row;
    logic [6:0] col;
    logic       data;
    bit         last;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  image_writer_if #(.NCOLS(NC)) bus ();

  image_writer #(.NCOLS(NC), .NROWS(NR)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  wr_t        sb[$];
  bit         exp_done = 0;
  logic [6:0] model_row = 0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [NC-1:0] rnd_row();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[NC-1:0];
  endfunction

  always @(negedge clk) begin
    if (rstn) begin
      if (exp_done) begin
        chk("row_done", {31'd0, bus.row_done}, 1);
        chk("we_after_seq", {31'd0, bus.we}, 0);
        exp_done = 0;
      end else if (bus.row_done) begin
        chk("row_done_spurious", {31'd0, bus.row_done}, 0);
      end
      if (bus.we) begin
        if (sb.size() == 0) begin
          fail("write_unexpected");
          $display("  row %0d col %0d", bus.rowW, bus.colW);
        end else begin
          wr_t e;
          e = sb.pop_front();
          chk("write", {17'd0, bus.rowW, bus.colW, bus.dataW},
              {17'd0, e.row, e.col, e.data});
          if (e.last) exp_done = 1;
        end
      end
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    sb.delete();
    exp_done = 0;
    model_row = 0;
    repeat (2) @(negedge clk);
    chk("rst_we", {31'd0, bus.we}, 0);
    chk("rst_done", {31'd0, bus.row_done}, 0);
    chk("rst_addr", {17'd0, bus.rowW, bus.colW, bus.dataW}, 0);
    chk("rst_cur_row", {25'd0, bus.cur_row}, 0);
    rstn = 1'b1;
    #1;
    chk("rst_ready", {31'd0, bus.row_ready}, 1);
  endtask

  task automatic send_row(input logic [NC-1:0] d,
                          input bit keep,
                          output time ta);
    int t;
    ta = 0;
    @(negedge clk);
    bus.row_valid = 1'b1;
    bus.row_data  = d;
    #1;
    t = 0;
    while (!bus.row_ready && t < 6000) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!bus.row_ready) begin
      fail("accept_timeout");
      bus.row_valid = 1'b0;
      return;
    end
    chk("cur_row", {25'd0, bus.cur_row}, {25'd0, model_row});
    for (int c = 0; c < NC; c++)
      sb.push_back('{model_row, 7'(c), d[c], c == NC-1});
    model_row = (model_row == NR-1) ? 7'd0 : model_row + 7'd1;
    @(posedge clk);
    ta = $time;
    if (!keep) begin
      @(negedge clk);
      bus.row_valid = 1'b0;
      bus.row_data  = rnd_row();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((sb.size() != 0 || exp_done) && t < 6000) begin
      @(negedge clk);
      t++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    time ta, tp;
    logic [NC-1:0] d;
    int t;
    bus.row_valid = 1'b0;
    bus.clear_req = 1'b0;
    bus.row_data  = '0;

    do_reset();
    d = '0;
    d[0] = 1'b1;
    send_row(d, 0, ta);
    drain();
    chk("cur_row_one", {25'd0, bus.cur_row}, 1);

    do_reset();
    tp = 0;
    for (int i = 0; i < 61; i++) begin
      send_row(rnd_row(), i != 60, ta);
      if (i > 0) chk("spacing", 32'((ta - tp) / 10), NC + 1);
      tp = ta;
    end
    drain();
    chk("cur_row_wrap", {25'd0, bus.cur_row}, 1);

    @(negedge clk);
    d = rnd_row();
    bus.clear_req = 1'b1;
    bus.row_valid = 1'b1;
    bus.row_data  = d;
    #1;
    chk("clear_wins", {31'd0, bus.row_ready}, 0);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        sb.push_back('{7'(r), 7'(c), 1'b0,
                       (r == NR-1) && (c == NC-1)});
    model_row = 0;
    @(negedge clk);
    bus.clear_req = 1'b0;
    send_row(d, 0, ta);
    drain();

    send_row(rnd_row(), 0, ta);
    repeat (20) @(negedge clk);
    bus.clear_req = 1'b1;
    #1;
    chk("busy_ready", {31'd0, bus.row_ready}, 0);
    @(negedge clk);
    bus.clear_req = 1'b0;
    drain();

    d = 80'hAAAA_AAAA_AAAA_AAAA_AAAA;
    send_row(d, 0, ta);
    repeat (NC + 4) begin
      @(negedge clk);
      bus.row_data = rnd_row();
    end
    drain();

    do_reset();
    for (int i = 0; i < 4; i++) send_row(rnd_row(), 0, ta);
    t = 0;
    while (!(bus.we && bus.colW == 7'd40 &&
             bus.rowW == 7'd3) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("reach_col40", {25'd0, bus.colW}, 40);
    #2;
    rstn = 1'b0;
    sb.delete();
    exp_done = 0;
    model_row = 0;
    #1;
    chk("async_we", {31'd0, bus.we}, 0);
    chk("async_cur_row", {25'd0, bus.cur_row}, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, bus.row_ready}, 1);
    repeat (100) @(negedge clk);
    chk("no_resume", sb.size(), 0);

    for (int i = 0; i < 5; i++) send_row(rnd_row(), 0, ta);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
